// File: rtl/matrix_dbuf.sv
// rtl/matrix_dbuf.sv - double-buffered row-scan frame store with async host write port
module matrix_dbuf #(
  parameter int ADDR_DEPTH = 4,
  parameter int CH_BITS    = 3,
  parameter int DATA_W     = 8,
  parameter int SCAN_DIV   = 1
) (
  input  logic                             clk_100mhz,
  input  logic                             reset,
  input  logic [DATA_W-1:0]                RPI_IO,
  input  logic                             write_strobe,
  input  logic                             frame_commit,
  input  logic                             scan_enable,
  output logic                             sync,
  output logic [ADDR_DEPTH-1:0]            row_addr,
  output logic [(2**CH_BITS)*DATA_W-1:0]   output_pin,
  output logic                             frame_pending,
  output logic                             overflow
);
  localparam int ROWS     = 2**ADDR_DEPTH;
  localparam int CHANNELS = 2**CH_BITS;
  localparam int ROW_W    = CHANNELS * DATA_W;
  localparam int PTR_W    = ADDR_DEPTH + CH_BITS;
  localparam int PS_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [ROW_W-1:0] buf_a [ROWS];
  logic [ROW_W-1:0] buf_b [ROWS];

  logic ws_meta, ws_sync, ws_prev;
  logic fc_meta, fc_sync, fc_prev;
  logic [PTR_W-1:0] wr_ptr;
  logic full;
  logic front_b;
  logic [PS_W-1:0] prescaler;

  logic write_edge, commit_edge, write_ok, tick, wrap, swap;
  logic [ADDR_DEPTH-1:0] next_row;
  logic [ADDR_DEPTH-1:0] wr_row;
  logic [CH_BITS-1:0] wr_ch;
  logic [ROW_W-1:0] row_data;

  assign write_edge  = ws_sync & ~ws_prev;
  assign commit_edge = fc_sync & ~fc_prev;
  assign write_ok    = write_edge & ~frame_pending & ~full;
  assign wr_ch       = wr_ptr[CH_BITS-1:0];
  assign wr_row      = wr_ptr[PTR_W-1:CH_BITS];
  assign tick        = scan_enable && (prescaler == PS_W'(SCAN_DIV - 1));
  assign next_row    = row_addr + 1'b1;
  assign wrap        = tick && (row_addr == ADDR_DEPTH'(ROWS - 1));
  assign swap        = wrap && frame_pending;
  // On a swapping wrap the row loaded must come from the buffer that becomes front.
  assign row_data    = (front_b ^ swap) ? buf_b[next_row] : buf_a[next_row];

  // Buffer contents deliberately survive reset.
  always_ff @(posedge clk_100mhz) begin
    if (!reset && write_ok) begin
      if (front_b) buf_a[wr_row][wr_ch*DATA_W +: DATA_W] <= RPI_IO;
      else         buf_b[wr_row][wr_ch*DATA_W +: DATA_W] <= RPI_IO;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      ws_meta       <= 1'b0;
      ws_sync       <= 1'b0;
      ws_prev       <= 1'b0;
      fc_meta       <= 1'b0;
      fc_sync       <= 1'b0;
      fc_prev       <= 1'b0;
      wr_ptr        <= '0;
      full          <= 1'b0;
      front_b       <= 1'b0;
      prescaler     <= '0;
      sync          <= 1'b0;
      row_addr      <= '0;
      output_pin    <= '0;
      frame_pending <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      ws_meta <= write_strobe;
      ws_sync <= ws_meta;
      ws_prev <= ws_sync;
      fc_meta <= frame_commit;
      fc_sync <= fc_meta;
      fc_prev <= fc_sync;
      sync    <= wrap;

      if (write_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == {PTR_W{1'b1}}) full <= 1'b1;
      end
      if (write_edge && (frame_pending || full)) overflow <= 1'b1;

      if (commit_edge) begin
        if (frame_pending) overflow      <= 1'b1;
        else               frame_pending <= 1'b1;
      end

      if (tick) begin
        prescaler  <= '0;
        row_addr   <= next_row;
        output_pin <= row_data;
      end else if (scan_enable) begin
        prescaler <= prescaler + 1'b1;
      end

      // A commit landing on this same wrap sees pending still low, so it waits a frame.
      if (swap) begin
        front_b       <= ~front_b;
        frame_pending <= 1'b0;
        wr_ptr        <= '0;
        full          <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_matrix_dbuf.sv
// tb/tb_matrix_dbuf.sv - directed self-checking bench for matrix_dbuf
module tb_matrix_dbuf;
  localparam int ROWS  = 4;
  localparam int WORDS = 8;

  logic clk_100mhz = 1'b0;
  logic reset = 1'b1;
  logic [7:0] RPI_IO = 8'h00;
  logic write_strobe = 1'b0;
  logic frame_commit = 1'b0;
  logic scan_enable = 1'b0;
  logic sync;
  logic [1:0] row_addr;
  logic [15:0] output_pin;
  logic frame_pending, overflow;

  logic scan_enable3 = 1'b0;
  logic sync3;
  logic [1:0] row3;
  logic [15:0] out3;
  logic pend3, ovf3;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  matrix_dbuf #(.ADDR_DEPTH(2), .CH_BITS(1), .DATA_W(8), .SCAN_DIV(1)) dut (
    .clk_100mhz(clk_100mhz), .reset(reset), .RPI_IO(RPI_IO),
    .write_strobe(write_strobe), .frame_commit(frame_commit), .scan_enable(scan_enable),
    .sync(sync), .row_addr(row_addr), .output_pin(output_pin),
    .frame_pending(frame_pending), .overflow(overflow)
  );

  matrix_dbuf #(.ADDR_DEPTH(2), .CH_BITS(1), .DATA_W(8), .SCAN_DIV(3)) dut3 (
    .clk_100mhz(clk_100mhz), .reset(reset), .RPI_IO(8'h00),
    .write_strobe(1'b0), .frame_commit(1'b0), .scan_enable(scan_enable3),
    .sync(sync3), .row_addr(row3), .output_pin(out3),
    .frame_pending(pend3), .overflow(ovf3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frames as flat word arrays, word index = row*2 + channel.
  logic [7:0] m_mem [2][WORDS];
  bit m_known [2][WORDS];
  int m_front = 0, m_wcnt = 0, m_row = 0;
  bit m_pend = 0, m_ovf = 0, m_loaded = 0, m_sync = 0, m_valid = 0;
  bit [2:0] w_hist = 0, c_hist = 0;
  logic m_we, m_ce, m_wrap;

  assign m_we   = w_hist[1] & ~w_hist[2];
  assign m_ce   = c_hist[1] & ~c_hist[2];
  assign m_wrap = scan_enable && (m_row == ROWS - 1);

  always @(posedge clk_100mhz) begin
    if (reset) begin
      w_hist <= 0; c_hist <= 0;
      m_front <= 0; m_wcnt <= 0; m_row <= 0;
      m_pend <= 0; m_ovf <= 0; m_loaded <= 0; m_sync <= 0; m_valid <= 1;
    end else begin
      w_hist <= {w_hist[1:0], write_strobe};
      c_hist <= {c_hist[1:0], frame_commit};
      m_sync <= m_wrap;
      if (m_we) begin
        if (m_pend || m_wcnt == WORDS) m_ovf <= 1;
        else begin
          m_mem[1-m_front][m_wcnt] <= RPI_IO;
          m_known[1-m_front][m_wcnt] <= 1;
          m_wcnt <= m_wcnt + 1;
        end
      end
      if (m_ce) begin
        if (m_pend) m_ovf <= 1;
        else        m_pend <= 1;
      end
      if (scan_enable) begin
        m_row <= (m_row + 1) % ROWS;
        m_loaded <= 1;
      end
      if (m_wrap && m_pend) begin
        m_front <= 1 - m_front;
        m_pend <= 0;
        m_wcnt <= 0;
      end
    end
  end

  function automatic logic [15:0] exp_row(input int f, input int r);
    return {m_mem[f][2*r+1], m_mem[f][2*r]};
  endfunction

  always @(negedge clk_100mhz) begin
    if (m_valid) begin
      check("sync", sync, m_sync);
      check("row_addr", row_addr, m_row);
      check("frame_pending", frame_pending, m_pend);
      check("overflow", overflow, m_ovf);
      if (!m_loaded)
        check("output_pin_idle", output_pin, 0);
      else if (m_known[m_front][2*m_row] && m_known[m_front][2*m_row+1])
        check("output_pin", output_pin, exp_row(m_front, m_row));
    end
  end

  task automatic strobe(input logic [7:0] d);
    RPI_IO = d;
    write_strobe = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    write_strobe = 1'b0;
    repeat (3) @(negedge clk_100mhz);
  endtask

  task automatic commit();
    frame_commit = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    frame_commit = 1'b0;
    repeat (3) @(negedge clk_100mhz);
  endtask

  task automatic wait_sync();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_100mhz);
      if (sync) begin ok = 1; break; end
    end
    check("sync_seen", ok, 1);
  endtask

  task automatic wait_sync3(output int t);
    bit ok;
    ok = 0;
    t = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_100mhz);
      if (sync3) begin ok = 1; t = cyc; break; end
    end
    check("sync3_seen", ok, 1);
  endtask

  initial begin
    logic [15:0] f1 [4];
    int pc, t0, t1, t2, nsync;
    logic [1:0] r_hold;
    f1 = '{16'h1110, 16'h1312, 16'h1514, 16'h1716};

    repeat (3) @(negedge clk_100mhz);
    check("rst_row", row_addr, 0);
    check("rst_out", output_pin, 0);
    check("rst_sync", sync, 0);
    check("rst_pend", frame_pending, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;

    // First frame into buffer B, swapped in at the first wrap.
    for (int i = 0; i < 8; i++) strobe(8'h10 + i[7:0]);
    check("f1_no_ovf", overflow, 0);
    commit();
    check("f1_pend", frame_pending, 1);
    scan_enable = 1'b1;
    wait_sync();
    check("f1_row0", output_pin, f1[0]);
    check("f1_row0_addr", row_addr, 0);
    for (int r = 1; r < 4; r++) begin
      @(negedge clk_100mhz);
      check("f1_row", output_pin, f1[r]);
      check("f1_nosync", sync, 0);
    end
    @(negedge clk_100mhz);
    check("f1_wrap_sync", sync, 1);
    check("f1_wrap_row0", output_pin, 16'h1110);
    check("f1_pend_clr", frame_pending, 0);
    scan_enable = 1'b0;

    // Second frame into A, ninth write overflows and must not land.
    for (int i = 0; i < 8; i++) strobe(8'h20 + i[7:0]);
    strobe(8'h99);
    check("ovf_9th", overflow, 1);
    commit();
    scan_enable = 1'b1;
    wait_sync();
    check("f2_row0", output_pin, 16'h2120);
    repeat (3) @(negedge clk_100mhz);
    check("f2_row3", output_pin, 16'h2726);
    check("ovf_sticky", overflow, 1);
    scan_enable = 1'b0;

    // Reset keeps buffers; write while pending is rejected.
    reset = 1'b1;
    @(negedge clk_100mhz);
    check("rst2_ovf", overflow, 0);
    check("rst2_out", output_pin, 0);
    reset = 1'b0;
    strobe(8'h30);
    commit();
    check("p_pend", frame_pending, 1);
    strobe(8'h31);
    check("p_ovf", overflow, 1);
    check("out_before_tick", output_pin, 0);
    scan_enable = 1'b1;
    @(negedge clk_100mhz);
    check("first_tick_row", row_addr, 1);
    check("first_tick_out", output_pin, 16'h2322);
    wait_sync();
    check("p_swap_row0", output_pin, 16'h1130);
    scan_enable = 1'b0;
    strobe(8'h40);
    commit();
    scan_enable = 1'b1;
    wait_sync();
    check("after_swap_w0", output_pin, 16'h2140);

    // Commit edge coincident with a wrap tick.
    @(negedge clk_100mhz);
    frame_commit = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    check("coin_sync", sync, 1);
    check("coin_pend", frame_pending, 1);
    check("coin_noswap", output_pin, 16'h2140);
    frame_commit = 1'b0;
    pc = int'(frame_pending);
    repeat (4) begin
      @(negedge clk_100mhz);
      pc += int'(frame_pending);
    end
    check("coin_pend_ticks", pc, 4);
    check("coin_swap_sync", sync, 1);
    check("coin_swap_out", output_pin, 16'h1130);
    @(negedge clk_100mhz);
    scan_enable = 1'b0;

    // Reset mid-frame with a commit pending.
    commit();
    check("mid_pend", frame_pending, 1);
    check("mid_row", row_addr, 1);
    reset = 1'b1;
    @(negedge clk_100mhz);
    check("mid_rst_row", row_addr, 0);
    check("mid_rst_out", output_pin, 0);
    check("mid_rst_pend", frame_pending, 0);
    reset = 1'b0;
    scan_enable = 1'b1;
    wait_sync();
    check("mid_front_a", output_pin, 16'h2140);
    scan_enable = 1'b0;

    // Prescaled scan on the SCAN_DIV=3 instance.
    scan_enable3 = 1'b1;
    wait_sync3(t0);
    for (int k = 1; k < 4; k++) begin
      repeat (2) @(negedge clk_100mhz);
      check("div3_hold", row3, k - 1);
      @(negedge clk_100mhz);
      check("div3_adv", row3, k);
    end
    wait_sync3(t1);
    check("div3_period", t1 - t0, 12);
    repeat (2) @(negedge clk_100mhz);
    scan_enable3 = 1'b0;
    r_hold = row3;
    nsync = 0;
    repeat (5) begin
      @(negedge clk_100mhz);
      nsync += int'(sync3);
      check("div3_frozen", row3, r_hold);
    end
    scan_enable3 = 1'b1;
    wait_sync3(t2);
    check("div3_nosync_hold", nsync, 0);
    check("div3_stretched", t2 - t1, 17);
    check("div3_pend", pend3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
